mdu_unit: RTL and testbench

- Multiply/divide unit in the EX stage, next to the ALU. It takes the same forwarded rs/rt operands.
- It owns the HI/LO registers. Its read port feeds the EX result mux, and from there the EX/MEM pipeline register.
- It models multi-cycle latency with a busy counter. The hazard unit uses busy to stall MDU-class instructions in D.

---
 rtl/mdu_unit.sv | 105 ++++++++++
 tb/tb_mdu_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// Multiply/divide unit: owns HI/LO, computes a result at issue, then holds it
// back for a fixed busy period so the pipeline sees multi-cycle latency.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  mdu_op,
  input  logic        start,
  input  logic        rd_sel,
  output logic        busy,
  output logic [31:0] out
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] hi, lo, n_hi, n_lo;

  // Multiply: sign- or zero-extend to 64 bits so one unsigned product serves both.
  logic        signed_mul, signed_div, b_zero;
  logic [63:0] mul_a, mul_b, prod;
  logic [31:0] abs_a, abs_b, div_d, uq, ur, quo, rem;

  always_comb begin
    signed_mul = (mdu_op == OP_MULT);
    signed_div = (mdu_op == OP_DIV);
    mul_a      = {{32{signed_mul & A[31]}}, A};
    mul_b      = {{32{signed_mul & B[31]}}, B};
    prod       = mul_a * mul_b;
    // Divide on magnitudes, then restore signs: quotient truncates toward zero,
    // remainder takes the dividend's sign. 0x80000000/-1 falls out naturally.
    abs_a      = (signed_div && A[31]) ? (~A + 32'd1) : A;
    abs_b      = (signed_div && B[31]) ? (~B + 32'd1) : B;
    b_zero     = (B == 32'd0);
    div_d      = b_zero ? 32'd1 : abs_b;
    uq         = abs_a / div_d;
    ur         = abs_a % div_d;
    quo        = (signed_div && (A[31] ^ B[31])) ? (~uq + 32'd1) : uq;
    rem        = (signed_div && A[31]) ? (~ur + 32'd1) : ur;
  end

  assign out = rd_sel ? hi : lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      busy  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      n_hi  <= 32'd0;
      n_lo  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (mdu_op)
              OP_MULT, OP_MULTU: begin
                n_hi  <= prod[63:32];
                n_lo  <= prod[31:0];
                cnt   <= 4'(MULT_CYCLES);
                busy  <= 1'b1;
                state <= MUL;
              end
              OP_DIV, OP_DIVU: begin
                // Divide by zero still takes the full latency but writes back the old values.
                n_hi  <= b_zero ? hi : rem;
                n_lo  <= b_zero ? lo : quo;
                cnt   <= 4'(DIV_CYCLES);
                busy  <= 1'b1;
                state <= DIV;
              end
              OP_MTHI: hi <= A;
              OP_MTLO: lo <= A;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            hi    <= n_hi;
            lo    <= n_lo;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: latency, HI/LO results, divide corner cases,
// start-while-busy robustness and asynchronous reset mid-operation.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] op_a, op_b;
  logic [2:0]  mdu_op;
  logic        start, rd_sel;
  logic        busy;
  logic [31:0] out;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(op_a), .B(op_b), .mdu_op(mdu_op),
    .start(start), .rd_sel(rd_sel), .busy(busy), .out(out)
  );

  always #5 clk = ~clk;

  // Issue one op at a rising edge, then count busy cycles sampled on falling edges.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    @(negedge clk);
    mdu_op = op; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; mdu_op = OP_NONE;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    rd_sel = 1'b1; #1 h = out;
    rd_sel = 1'b0; #1 l = out;
  endtask

  task automatic test_reset();
    logic [31:0] h, l;
    reset = 1'b1; start = 1'b0; mdu_op = OP_NONE; op_a = '0; op_b = '0; rd_sel = 1'b0;
    #2;
    read_hilo(h, l);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (h !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", h); end
    checks++; if (l !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", l); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mult();
    logic [31:0] h, l;
    int n = 0;
    @(negedge clk);
    mdu_op = OP_MULT; op_a = 32'hFFFF_FFFE; op_b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; mdu_op = OP_NONE;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      rd_sel = n[0]; #1;
      checks++;
      if (out !== 32'd0) begin errors++; $display("FAIL mult_out_during_busy cyc=%0d got=%h exp=0", n, out); end
    end
    checks++; if (n != 5) begin errors++; $display("FAIL mult_busy_len got=%0d exp=5", n); end
    read_hilo(h, l);
    checks++; if (h !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", h); end
    checks++; if (l !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got=%h exp=fffffffa", l); end
  endtask

  task automatic test_multu();
    logic [31:0] h, l;
    int n;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    read_hilo(h, l);
    checks++; if (n != 5) begin errors++; $display("FAIL multu_busy_len got=%0d exp=5", n); end
    checks++; if (h !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got=%h exp=fffffffe", h); end
    checks++; if (l !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got=%h exp=00000001", l); end
  endtask

  task automatic test_div();
    logic [31:0] h, l;
    int n;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, n);
    read_hilo(h, l);
    checks++; if (n != 10) begin errors++; $display("FAIL div_busy_len got=%0d exp=10", n); end
    checks++; if (l !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo got=%h exp=fffffffd", l); end
    checks++; if (h !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi got=%h exp=ffffffff", h); end
    // 7 / -2 = -3 remainder +1 (remainder follows the dividend)
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, n);
    read_hilo(h, l);
    checks++; if (l !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negdiv_lo got=%h exp=fffffffd", l); end
    checks++; if (h !== 32'h0000_0001) begin errors++; $display("FAIL div_negdiv_hi got=%h exp=00000001", h); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    read_hilo(h, l);
    checks++; if (l !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got=%h exp=80000000", l); end
    checks++; if (h !== 32'h0000_0000) begin errors++; $display("FAIL div_ovf_hi got=%h exp=00000000", h); end
    // unsigned view of the same bits: 0x80000000 / 0xFFFFFFFF = 0 rem 0x80000000
    run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, n);
    read_hilo(h, l);
    checks++; if (l !== 32'h0000_0000) begin errors++; $display("FAIL divu_lo got=%h exp=00000000", l); end
    checks++; if (h !== 32'h8000_0000) begin errors++; $display("FAIL divu_hi got=%h exp=80000000", h); end
  endtask

  task automatic test_div_zero();
    logic [31:0] h, l;
    int n;
    run_op(OP_MTHI, 32'h11, 32'd0, n);
    checks++; if (n != 0) begin errors++; $display("FAIL mthi_busy got=%0d exp=0", n); end
    run_op(OP_MTLO, 32'h22, 32'd0, n);
    read_hilo(h, l);
    checks++; if (h !== 32'h11) begin errors++; $display("FAIL mthi_val got=%h exp=00000011", h); end
    checks++; if (l !== 32'h22) begin errors++; $display("FAIL mtlo_val got=%h exp=00000022", l); end
    run_op(OP_DIVU, 32'd7, 32'd0, n);
    read_hilo(h, l);
    checks++; if (n != 10) begin errors++; $display("FAIL divz_busy_len got=%0d exp=10", n); end
    checks++; if (h !== 32'h11) begin errors++; $display("FAIL divz_hi got=%h exp=00000011", h); end
    checks++; if (l !== 32'h22) begin errors++; $display("FAIL divz_lo got=%h exp=00000022", l); end
  endtask

  task automatic test_ignore_while_busy();
    logic [31:0] h, l;
    int n = 0;
    @(negedge clk);
    mdu_op = OP_MULT; op_a = 32'd6; op_b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; mdu_op = OP_NONE;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0; mdu_op = OP_NONE;
      if (!busy) break;
      n++;
      if (n == 2) begin mdu_op = OP_MTLO; op_a = 32'h55; start = 1'b1; end
    end
    read_hilo(h, l);
    checks++; if (n != 5) begin errors++; $display("FAIL busy_ign_len got=%0d exp=5", n); end
    checks++; if (l !== 32'd42) begin errors++; $display("FAIL busy_ign_lo got=%h exp=0000002a", l); end
    checks++; if (h !== 32'd0) begin errors++; $display("FAIL busy_ign_hi got=%h exp=00000000", h); end
  endtask

  task automatic test_noop();
    logic [31:0] h, l;
    int n;
    run_op(OP_NONE, 32'hDEAD_BEEF, 32'd3, n);
    checks++; if (n != 0) begin errors++; $display("FAIL none_busy got=%0d exp=0", n); end
    run_op(OP_RSVD, 32'hDEAD_BEEF, 32'd3, n);
    read_hilo(h, l);
    checks++; if (n != 0) begin errors++; $display("FAIL rsvd_busy got=%0d exp=0", n); end
    checks++; if (h !== 32'd0 || l !== 32'd42) begin
      errors++; $display("FAIL noop_hilo got=%h_%h exp=00000000_0000002a", h, l);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] h, l;
    int n;
    run_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000, n);
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, n);
    read_hilo(h, l);
    checks++; if (h !== 32'h4000_0000 || l !== 32'd0) begin
      errors++; $display("FAIL b2b_mult got=%h_%h exp=40000000_00000000", h, l);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] h, l;
    int n = 0;
    run_op(OP_MTHI, 32'hAA, 32'd0, n);
    n = 0;
    @(negedge clk);
    mdu_op = OP_DIV; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; mdu_op = OP_NONE;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n == 4) break;
    end
    checks++; if (n != 4) begin errors++; $display("FAIL rmid_reach got=%0d exp=4", n); end
    reset = 1'b1;
    #1;
    read_hilo(h, l);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%0b exp=0", busy); end
    checks++; if (h !== 32'd0 || l !== 32'd0) begin
      errors++; $display("FAIL rmid_hilo got=%h_%h exp=00000000_00000000", h, l);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    read_hilo(h, l);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_late got=%0b exp=0", busy); end
    checks++; if (h !== 32'd0 || l !== 32'd0) begin
      errors++; $display("FAIL rmid_hilo_late got=%h_%h exp=00000000_00000000", h, l);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_zero();
    test_ignore_while_busy();
    test_noop();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
